// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin arbiter that sequences one request at a time through the
// shared fixed-latency ALU and returns its result/flag to the granted client.
module alu_rr_arbiter #(
  parameter int WIDTH   = 6,
  parameter int OPW     = 2,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             busy,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;   // 1: client 1 was granted last
  logic               sel_q, sel_d;     // client owning the op in flight
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               rv0_q, rv0_d, rv1_q, rv1_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               flag_q, flag_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [OPW-1:0]     op_q, op_d;
  logic               pick1;

  // Client 1 wins when it is the only requester, or on a tie when client 0 went last.
  assign pick1 = req1 & (~req0 | ~last_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    start_d = 1'b0;
    res_d   = res_q;
    flag_d  = flag_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          sel_d   = pick1;
          last_d  = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          start_d = 1'b1;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          op_d    = pick1 ? op1 : op0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          res_d   = alu_result;
          flag_d  = alu_flag;
          rv0_d   = ~sel_q;
          rv1_d   = sel_q;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= {OPW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rsp_valid0 = rv0_q;
  assign rsp_valid1 = rv1_q;
  assign rsp_result = res_q;
  assign rsp_flag   = flag_q;
  assign busy       = busy_q;
  assign alu_start  = start_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;

endmodule
